seg7_sequencer: RTL and testbench



---
 rtl/seg7_sequencer.sv | 68 ++++++
 tb/tb_seg7_sequencer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/seg7_sequencer.sv
// seg7_sequencer: prescaled frame counter with per-animation wrap and a
// debounced button that cycles the animation ID for the seg7 decoder.
module seg7_sequencer #(
   parameter int TICK_DIV   = 1000000,
   parameter int DEB_CYCLES = 50000,
   parameter int NUM_ANIM   = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       dir,
   input  logic       btn,
   output logic [3:0] counter,
   output logic [2:0] animation,
   output logic       frame_tick
);
   localparam int PW = $clog2(TICK_DIV);
   localparam int DW = $clog2(DEB_CYCLES + 1);
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
   localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
   localparam logic [2:0] ANIM_LAST = 3'(NUM_ANIM - 1);
   logic [PW-1:0] pre;
   logic [DW-1:0] deb_cnt;
   logic s1, s2, deb, press, step;
   logic [3:0] last, next;
   // press fires on the very edge the debounced level rises
   always_comb begin
      press = s2 && !deb && deb_cnt == DEB_LAST;
      step  = en && pre == PRE_LAST;
      last  = animation == 3'd0 ? 4'd9 : 4'd6;
      next  = dir ? (counter == 4'd0 ? last : counter - 4'd1)
                  : (counter == last ? 4'd0 : counter + 4'd1);
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         s1      <= 1'b0;
         s2      <= 1'b0;
         deb     <= 1'b0;
         deb_cnt <= '0;
      end else begin
         s1 <= btn;
         s2 <= s1;
         if (s2 == deb) deb_cnt <= '0;
         else if (deb_cnt == DEB_LAST) begin
            deb     <= s2;
            deb_cnt <= '0;
         end else deb_cnt <= deb_cnt + 1'b1;
      end
   // a press overrides any coincident step and restarts the frame timing
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         pre        <= '0;
         counter    <= 4'd0;
         animation  <= 3'd0;
         frame_tick <= 1'b0;
      end else if (press) begin
         pre        <= '0;
         counter    <= 4'd0;
         animation  <= animation == ANIM_LAST ? 3'd0 : animation + 3'd1;
         frame_tick <= 1'b0;
      end else begin
         frame_tick <= step;
         if (step) begin
            pre     <= '0;
            counter <= next;
         end else if (en) pre <= pre + 1'b1;
      end
endmodule

// File: tb/tb_seg7_sequencer.sv
// tb_seg7_sequencer: directed vector table, reset/corner sequences and a
// randomized run against a cycle-level reference model.
module tb_seg7_sequencer;
   localparam int TD = 4;
   localparam int DC = 3;
   localparam int NA = 3;
   logic clk = 1'b0, rst = 1'b1, en = 1'b0, dir = 1'b0, btn = 1'b0;
   logic [3:0] counter;
   logic [2:0] animation;
   logic frame_tick;
   int errors = 0, checks = 0;
   bit use_model = 0;
   int m_cnt, m_anim, m_ph;
   bit m_tick, m_deb;
   bit bq[$];

   seg7_sequencer #(.TICK_DIV(TD), .DEB_CYCLES(DC), .NUM_ANIM(NA)) dut (
      .clk(clk), .rst(rst), .en(en), .dir(dir), .btn(btn),
      .counter(counter), .animation(animation), .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   typedef struct {
      int n;
      logic en, dir, btn;
      logic [3:0] c;
      logic [2:0] a;
      logic t;
   } vec_t;
   vec_t tbl[22];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_cnt = 0; m_anim = 0; m_ph = 0; m_tick = 0; m_deb = 0;
      bq = {};
      for (int i = 0; i < DC + 2; i++) bq.push_back(1'b0);
   endfunction

   // deb flips once the DC samples seen by the second sync stage all disagree with it
   function automatic void model_edge();
      bit flip = 1, press = 0;
      int len;
      bq.push_back(btn);
      for (int i = 2; i <= DC + 1; i++) if (bq[bq.size() - 1 - i] == m_deb) flip = 0;
      if (flip) begin
         m_deb = !m_deb;
         press = m_deb;
      end
      len = m_anim == 0 ? 10 : 7;
      if (press) begin
         m_anim = (m_anim + 1) % NA;
         m_cnt = 0; m_ph = 0; m_tick = 0;
      end else if (en) begin
         m_tick = (m_ph == TD - 1);
         m_ph = (m_ph + 1) % TD;
         if (m_tick) m_cnt = dir ? (m_cnt + len - 1) % len : (m_cnt + 1) % len;
      end else m_tick = 0;
      if (bq.size() > 64) void'(bq.pop_front());
   endfunction

   task automatic tick();
      @(posedge clk);
      if (rst) model_reset(); else model_edge();
      #1;
      if (use_model) begin
         chk("rand_counter", 32'(counter), 32'(m_cnt));
         chk("rand_animation", 32'(animation), 32'(m_anim));
         chk("rand_frame_tick", 32'(frame_tick), 32'(m_tick));
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      int hold = 0;
      tbl[0]  = '{4,  1, 0, 0, 4'd1, 3'd0, 1};
      tbl[1]  = '{1,  1, 0, 0, 4'd1, 3'd0, 0};
      tbl[2]  = '{35, 1, 0, 0, 4'd0, 3'd0, 1};
      tbl[3]  = '{12, 1, 0, 0, 4'd3, 3'd0, 1};
      tbl[4]  = '{50, 0, 0, 0, 4'd3, 3'd0, 0};
      tbl[5]  = '{5,  0, 0, 1, 4'd0, 3'd1, 0};
      tbl[6]  = '{20, 0, 0, 1, 4'd0, 3'd1, 0};
      tbl[7]  = '{10, 0, 0, 0, 4'd0, 3'd1, 0};
      tbl[8]  = '{3,  1, 1, 0, 4'd0, 3'd1, 0};
      tbl[9]  = '{1,  1, 1, 0, 4'd6, 3'd1, 1};
      tbl[10] = '{24, 1, 1, 0, 4'd0, 3'd1, 1};
      tbl[11] = '{4,  1, 1, 0, 4'd6, 3'd1, 1};
      tbl[12] = '{2,  1, 1, 1, 4'd6, 3'd1, 0};
      tbl[13] = '{6,  1, 1, 0, 4'd4, 3'd1, 1};
      tbl[14] = '{3,  1, 0, 0, 4'd4, 3'd1, 0};
      tbl[15] = '{4,  1, 0, 1, 4'd5, 3'd1, 0};
      tbl[16] = '{1,  1, 0, 1, 4'd0, 3'd2, 0};
      tbl[17] = '{3,  1, 0, 1, 4'd0, 3'd2, 0};
      tbl[18] = '{1,  1, 0, 1, 4'd1, 3'd2, 1};
      tbl[19] = '{10, 0, 0, 0, 4'd1, 3'd2, 0};
      tbl[20] = '{6,  0, 0, 1, 4'd0, 3'd0, 0};
      tbl[21] = '{6,  0, 0, 0, 4'd0, 3'd0, 0};

      do_reset();
      chk("reset_counter", 32'(counter), 0);
      chk("reset_animation", 32'(animation), 0);
      chk("reset_frame_tick", 32'(frame_tick), 0);
      for (int i = 0; i < 22; i++) begin
         en = tbl[i].en; dir = tbl[i].dir; btn = tbl[i].btn;
         run(tbl[i].n);
         chk($sformatf("vec%0d_counter", i), 32'(counter), 32'(tbl[i].c));
         chk($sformatf("vec%0d_animation", i), 32'(animation), 32'(tbl[i].a));
         chk($sformatf("vec%0d_frame_tick", i), 32'(frame_tick), 32'(tbl[i].t));
      end

      // asynchronous reset in the middle of a count
      do_reset();
      en = 0; dir = 0; btn = 1;
      run(5);
      btn = 0;
      run(6);
      en = 1;
      run(20);
      chk("pre_rst_counter", 32'(counter), 5);
      chk("pre_rst_animation", 32'(animation), 1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_counter", 32'(counter), 0);
      chk("async_rst_animation", 32'(animation), 0);
      chk("async_rst_frame_tick", 32'(frame_tick), 0);
      model_reset();
      @(negedge clk) rst = 1'b0;
      run(3);
      chk("post_rst_no_tick", 32'(frame_tick), 0);
      chk("post_rst_counter0", 32'(counter), 0);
      run(1);
      chk("post_rst_tick", 32'(frame_tick), 1);
      chk("post_rst_counter1", 32'(counter), 1);

      // randomized run against the reference model
      do_reset();
      use_model = 1;
      for (int i = 0; i < 3000; i++) begin
         if (hold == 0) begin
            btn = 1'($urandom_range(0, 1));
            hold = $urandom_range(1, 8);
         end
         hold--;
         en = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 15) == 0) dir = ~dir;
         tick();
      end
      use_model = 0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
